// File: rtl/jbi_min_wdq_pkg.sv
// Shared WDQ definitions: geometry, 156-bit entry layout and the per-lane ECC generator.
// Latency: none (types, constants and a combinational function only).
// Backpressure: n/a.
package jbi_min_wdq_pkg;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 128;
    localparam int ECC_W   = 7;
    localparam int LANES   = 4;
    localparam int LANE_W  = 32;

    // Entry layout: {ecc3, ecc2, ecc1, ecc0, data[127:0]}
    localparam int ENTRY_W  = DATA_W + LANES * ECC_W;
    localparam int DATA_LSB = 0;
    localparam int ECC_LSB  = DATA_W;

    // What the consumer sees per entry: payload plus one mismatch flag per lane.
    typedef struct packed {
        logic [LANES-1:0]  err;
        logic [DATA_W-1:0] data;
    } wdq_out_t;

    // Check bits for one 32-bit lane. Bits 0..5 are parities over data bits grouped by
    // the binary weight of their 1-based position; bit 6 is the parity of the whole lane,
    // so every single-bit flip in the lane changes at least one check bit.
    function automatic logic [ECC_W-1:0] jbi_ecc32_gen(input logic [LANE_W-1:0] d);
        logic [ECC_W-1:0] c;
        logic [5:0]       pos;
        c = '0;
        for (int i = 0; i < LANE_W; i++) begin
            pos = 6'(i + 1);
            for (int j = 0; j < 6; j++) begin
                if (pos[j]) c[j] = c[j] ^ d[i];
            end
            c[6] = c[6] ^ d[i];
        end
        return c;
    endfunction

endpackage

// File: rtl/jbi_min_wdq_rdctl_if.sv
// Bundle of the WDQ read-side signals: writer pointer, RAM read port and consumer handshake.
// Latency: none (wires only).
// Backpressure: out_rdy travels master->slave alongside the other slave inputs.
interface jbi_min_wdq_rdctl_if;
    import jbi_min_wdq_pkg::*;

    logic [ADDR_W:0]    wdq_wptr;
    logic               wdq_rd_en;
    logic [ADDR_W-1:0]  wdq_raddr;
    logic [ENTRY_W-1:0] wdq_rdata;
    logic [ADDR_W:0]    wdq_rptr;
    logic               out_vld;
    logic               out_rdy;
    logic [DATA_W-1:0]  out_data;
    logic [LANES-1:0]   out_ecc_err;
    logic               wdq_empty;

    // Writer / RAM / consumer side
    modport master (
        output wdq_wptr, wdq_rdata, out_rdy,
        input  wdq_rd_en, wdq_raddr, wdq_rptr, out_vld, out_data, out_ecc_err, wdq_empty
    );

    // Read controller side
    modport slave (
        input  wdq_wptr, wdq_rdata, out_rdy,
        output wdq_rd_en, wdq_raddr, wdq_rptr, out_vld, out_data, out_ecc_err, wdq_empty
    );

endinterface

// File: rtl/jbi_min_wdq_skid.sv
// Two-entry valid/ready skid FIFO; the head is always presented straight from a register.
// Latency: 1 cycle from in_vld to out_vld.
// Backpressure: no in_rdy; the producer must gate pushes on cnt (push with cnt==2 is illegal).
module jbi_min_wdq_skid #(
    parameter int WIDTH = 132
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic [1:0]       cnt
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       cnt_q;
    logic             pop;

    assign pop     = out_vld & out_rdy;
    assign out_vld = (cnt_q != 2'd0);
    assign out_dat = head_q;
    assign cnt     = cnt_q;

    // Head/tail shuffle: the head only changes on a pop or when filling an empty buffer,
    // so a stalled head stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({in_vld, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= in_dat;
                    else               tail_q <= in_dat;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= in_dat;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    // The issue throttle upstream guarantees a push never lands on a full buffer.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(in_vld && cnt_q == 2'd2));

endmodule

// File: rtl/jbi_min_wdq_rdctl.sv
// WDQ read controller: issues RAM reads, absorbs the 1-cycle read latency, flags per-lane ECC.
// Latency: 2 cycles from issue to out_vld (RAM read + skid capture).
// Backpressure: out_rdy low stops issue once skid + inflight reaches 2; head held stable.
module jbi_min_wdq_rdctl
    import jbi_min_wdq_pkg::*;
(
    input logic               clk,
    input logic               rst,
    jbi_min_wdq_rdctl_if.slave wdq
);

    logic [ADDR_W:0]  issue_ptr;
    logic [ADDR_W:0]  rptr_q;
    logic             inflight;
    logic [1:0]       skid_cnt;
    logic             avail;
    logic             pop;
    logic             rd_en;
    logic [2:0]       occ;
    logic [LANES-1:0] lane_err;
    wdq_out_t         cap_ent;
    wdq_out_t         head_ent;

    // Wrap bit distinguishes full from empty, so plain inequality means "entries waiting".
    assign avail = (wdq.wdq_wptr != issue_ptr);
    assign pop   = wdq.out_vld & wdq.out_rdy;
    // Slots that will be committed after this edge if nothing new is issued.
    assign occ   = {1'b0, skid_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign rd_en = ~rst & avail & (occ < 3'd2);

    assign wdq.wdq_rd_en = rd_en;
    assign wdq.wdq_raddr = issue_ptr[ADDR_W-1:0];
    assign wdq.wdq_rptr  = rptr_q;
    assign wdq.wdq_empty = ~avail & ~inflight & (skid_cnt == 2'd0);

    // Issue pointer runs ahead; the committed pointer only moves once the data is captured,
    // so the writer never reuses a slot whose read is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_ptr <= '0;
            rptr_q    <= '0;
            inflight  <= 1'b0;
        end else begin
            if (rd_en)    issue_ptr <= issue_ptr + 1'b1;
            if (inflight) rptr_q    <= rptr_q + 1'b1;
            inflight <= rd_en;
        end
    end

    // Per-lane ECC recompute on the returning RAM word; errors are flagged, never corrected.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_err[g] = jbi_ecc32_gen(wdq.wdq_rdata[DATA_LSB + g*LANE_W +: LANE_W])
                             != wdq.wdq_rdata[ECC_LSB + g*ECC_W +: ECC_W];
    end

    assign cap_ent.err  = lane_err;
    assign cap_ent.data = wdq.wdq_rdata[DATA_LSB +: DATA_W];

    jbi_min_wdq_skid #(
        .WIDTH ($bits(wdq_out_t))
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (inflight),
        .in_dat  (cap_ent),
        .out_vld (wdq.out_vld),
        .out_rdy (wdq.out_rdy),
        .out_dat (head_ent),
        .cnt     (skid_cnt)
    );

    assign wdq.out_data    = head_ent.data;
    assign wdq.out_ecc_err = head_ent.err;

endmodule

// File: tb/tb_jbi_min_wdq_rdctl.sv
`timescale 1ns/1ps
module tb_jbi_min_wdq_rdctl;
    import jbi_min_wdq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jbi_min_wdq_rdctl_if wdq();

    jbi_min_wdq_rdctl dut (
        .clk (clk),
        .rst (rst),
        .wdq (wdq)
    );

    // WDQ RAM model: 1-cycle registered read
    logic [ENTRY_W-1:0] mem [0:15];
    logic [ENTRY_W-1:0] rdata_q = '0;
    always @(posedge clk) if (wdq.wdq_rd_en) rdata_q <= mem[wdq.wdq_raddr];
    assign wdq.wdq_rdata = rdata_q;

    int n_chk  = 0;
    int n_fail = 0;
    logic [131:0] sb [$];

    // Writer: store one entry with correct ECC (optionally bit 0 of chosen lanes' ECC flipped)
    task automatic push_entry(input logic [3:0] flip);
        logic [127:0]       d;
        logic [ENTRY_W-1:0] e;
        logic [6:0]         c;
        d = {$urandom, $urandom, $urandom, $urandom};
        e = '0;
        e[127:0] = d;
        for (int l = 0; l < 4; l++) begin
            c = jbi_ecc32_gen(d[32*l +: 32]);
            if (flip[l]) c[0] = ~c[0];
            e[128 + 7*l +: 7] = c;
        end
        mem[wdq.wdq_wptr[3:0]] = e;
        sb.push_back({flip, d});
        wdq.wdq_wptr = wdq.wdq_wptr + 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wdq.wdq_wptr = '0;
        wdq.out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (wdq.wdq_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en_in_rst: got %b want 0", wdq.wdq_rd_en); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++;
        if ({wdq.wdq_rd_en, wdq.wdq_raddr, wdq.out_vld, wdq.out_ecc_err, wdq.wdq_empty, wdq.wdq_rptr} !== {1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL reset_state: rd_en=%b raddr=%0d vld=%b err=%b empty=%b rptr=%0d want 0 0 0 0000 1 0",
                     wdq.wdq_rd_en, wdq.wdq_raddr, wdq.out_vld, wdq.out_ecc_err, wdq.wdq_empty, wdq.wdq_rptr);
        end
        n_chk++;
        if (wdq.out_data !== 128'd0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", wdq.out_data); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            n_chk++;
            if ({wdq.wdq_rd_en, wdq.out_vld, wdq.wdq_empty, wdq.wdq_rptr} !== {1'b0, 1'b0, 1'b1, 5'd0}) begin
                n_fail++;
                $display("FAIL idle_hold: rd_en=%b vld=%b empty=%b rptr=%0d want 0 0 1 0", wdq.wdq_rd_en, wdq.out_vld, wdq.wdq_empty, wdq.wdq_rptr);
            end
        end
    endtask

    task automatic test_basic;
        int first_iss, first_vld, last_vld, n_vld, n_iss;
        logic [3:0]   exp_addr;
        logic [131:0] exp;
        first_iss = -1; first_vld = -1; last_vld = -1; n_vld = 0; n_iss = 0; exp_addr = 4'd0;
        @(negedge clk);
        wdq.out_rdy = 1'b1;
        repeat (3) push_entry(4'b0000);
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            if (wdq.wdq_rd_en) begin
                if (first_iss < 0) first_iss = cyc;
                n_iss++;
                n_chk++;
                if (wdq.wdq_raddr !== exp_addr) begin n_fail++; $display("FAIL basic_raddr: got %0d want %0d", wdq.wdq_raddr, exp_addr); end
                exp_addr++;
            end
            if (wdq.out_vld) begin
                if (first_vld < 0) first_vld = cyc;
                last_vld = cyc;
                n_vld++;
            end
            if (wdq.out_vld && wdq.out_rdy) begin
                n_chk++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL basic_pop: unexpected entry %h", wdq.out_data); end
                else begin
                    exp = sb.pop_front();
                    if ({wdq.out_ecc_err, wdq.out_data} !== exp) begin
                        n_fail++;
                        $display("FAIL basic_pop: got err=%b data=%h want err=%b data=%h", wdq.out_ecc_err, wdq.out_data, exp[131:128], exp[127:0]);
                    end
                end
            end
        end
        n_chk++;
        if (n_iss != 3) begin n_fail++; $display("FAIL basic_issue_count: got %0d want 3", n_iss); end
        n_chk++;
        if (first_vld - first_iss != 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", first_vld - first_iss); end
        n_chk++;
        if (n_vld != 3 || last_vld - first_vld != 2) begin n_fail++; $display("FAIL basic_vld_run: got %0d cycles span %0d want 3 span 2", n_vld, last_vld - first_vld); end
        n_chk++;
        if (wdq.wdq_rptr !== 5'd3 || wdq.wdq_empty !== 1'b1) begin n_fail++; $display("FAIL basic_rptr: got rptr=%0d empty=%b want 3 1", wdq.wdq_rptr, wdq.wdq_empty); end
    endtask

    task automatic test_backpressure;
        int n_iss, n_pop, first_pop, last_pop;
        logic [131:0] exp;
        n_iss = 0; n_pop = 0; first_pop = -1; last_pop = -1;
        @(negedge clk);
        wdq.out_rdy = 1'b0;
        repeat (5) push_entry(4'b0000);
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            if (wdq.wdq_rd_en) n_iss++;
            if (wdq.out_vld) begin
                n_chk++;
                if ({wdq.out_ecc_err, wdq.out_data} !== sb[0]) begin
                    n_fail++;
                    $display("FAIL bp_hold: got %h want %h", {wdq.out_ecc_err, wdq.out_data}, sb[0]);
                end
            end
        end
        n_chk++;
        if (n_iss != 2) begin n_fail++; $display("FAIL bp_issue_count: got %0d want 2", n_iss); end
        n_chk++;
        if (dut.u_skid.cnt_q !== 2'd2 || wdq.out_vld !== 1'b1) begin n_fail++; $display("FAIL bp_skid_full: cnt=%0d vld=%b want 2 1", dut.u_skid.cnt_q, wdq.out_vld); end
        @(negedge clk);
        wdq.out_rdy = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            if (wdq.out_vld && wdq.out_rdy) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                n_pop++;
                n_chk++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL bp_pop: unexpected entry %h", wdq.out_data); end
                else begin
                    exp = sb.pop_front();
                    if ({wdq.out_ecc_err, wdq.out_data} !== exp) begin
                        n_fail++;
                        $display("FAIL bp_pop: got err=%b data=%h want err=%b data=%h", wdq.out_ecc_err, wdq.out_data, exp[131:128], exp[127:0]);
                    end
                end
            end
        end
        n_chk++;
        if (n_pop != 5 || last_pop - first_pop != 4) begin n_fail++; $display("FAIL bp_drain: got %0d pops span %0d want 5 span 4", n_pop, last_pop - first_pop); end
        n_chk++;
        if (wdq.wdq_rptr !== 5'd8) begin n_fail++; $display("FAIL bp_rptr: got %0d want 8", wdq.wdq_rptr); end
    endtask

    task automatic test_wrap;
        logic [3:0]   addrs [$];
        logic [3:0]   exp_a [4];
        logic [131:0] exp;
        exp_a = '{4'd14, 4'd15, 4'd0, 4'd1};
        @(negedge clk);
        wdq.out_rdy = 1'b1;
        repeat (6) push_entry(4'b0000);
        for (int phase = 0; phase < 2; phase++) begin
            for (int cyc = 0; cyc < 14; cyc++) begin
                if (cyc != 0) @(negedge clk);
                #1;
                if (phase == 1 && wdq.wdq_rd_en) addrs.push_back(wdq.wdq_raddr);
                if (wdq.out_vld && wdq.out_rdy) begin
                    n_chk++;
                    if (sb.size() == 0) begin n_fail++; $display("FAIL wrap_pop: unexpected entry %h", wdq.out_data); end
                    else begin
                        exp = sb.pop_front();
                        if ({wdq.out_ecc_err, wdq.out_data} !== exp) begin
                            n_fail++;
                            $display("FAIL wrap_pop: got err=%b data=%h want err=%b data=%h", wdq.out_ecc_err, wdq.out_data, exp[131:128], exp[127:0]);
                        end
                    end
                end
            end
            if (phase == 0) begin
                n_chk++;
                if (wdq.wdq_rptr !== 5'd14) begin n_fail++; $display("FAIL wrap_pre_rptr: got %0d want 14", wdq.wdq_rptr); end
                @(negedge clk);
                repeat (4) push_entry(4'b0000);
            end
        end
        n_chk++;
        if (addrs.size() != 4) begin n_fail++; $display("FAIL wrap_issue_count: got %0d want 4", addrs.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (addrs[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_raddr[%0d]: got %0d want %0d", i, addrs[i], exp_a[i]); end
            end
        end
        n_chk++;
        if (wdq.wdq_rptr !== 5'b10010 || wdq.wdq_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_rptr: got %b empty=%b want 10010 1", wdq.wdq_rptr, wdq.wdq_empty); end
    endtask

    task automatic test_ecc;
        logic [31:0]  w;
        logic [131:0] exp;
        int n_pop;
        n_pop = 0;
        w = 32'h0000_0001;
        n_chk++;
        if (jbi_ecc32_gen(w) !== 7'h41) begin n_fail++; $display("FAIL ecc_gen_lsb: got %h want 41", jbi_ecc32_gen(w)); end
        w = 32'h8000_0000;
        n_chk++;
        if (jbi_ecc32_gen(w) !== 7'h60) begin n_fail++; $display("FAIL ecc_gen_msb: got %h want 60", jbi_ecc32_gen(w)); end
        @(negedge clk);
        wdq.out_rdy = 1'b1;
        push_entry(4'b0000);
        push_entry(4'b0100);
        push_entry(4'b0000);
        push_entry(4'b1001);
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            if (wdq.out_vld && wdq.out_rdy) begin
                n_pop++;
                n_chk++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL ecc_pop: unexpected entry %h", wdq.out_data); end
                else begin
                    exp = sb.pop_front();
                    if ({wdq.out_ecc_err, wdq.out_data} !== exp) begin
                        n_fail++;
                        $display("FAIL ecc_pop: got err=%b data=%h want err=%b data=%h", wdq.out_ecc_err, wdq.out_data, exp[131:128], exp[127:0]);
                    end
                end
            end
        end
        n_chk++;
        if (n_pop != 4 || wdq.wdq_rptr !== 5'd22) begin n_fail++; $display("FAIL ecc_drain: got %0d pops rptr=%0d want 4 22", n_pop, wdq.wdq_rptr); end
    endtask

    task automatic test_reset_midop;
        logic [131:0] exp;
        int n_pop;
        n_pop = 0;
        @(negedge clk);
        wdq.out_rdy = 1'b1;
        push_entry(4'b0000);
        push_entry(4'b0000);
        #1;
        n_chk++;
        if (wdq.wdq_rd_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_issue: got %b want 1", wdq.wdq_rd_en); end
        @(negedge clk);
        rst = 1'b1;
        wdq.wdq_wptr = '0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            n_chk++;
            if ({wdq.out_vld, wdq.wdq_rptr, wdq.wdq_rd_en, wdq.wdq_empty} !== {1'b0, 5'd0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL rst_mid_state: vld=%b rptr=%0d rd_en=%b empty=%b want 0 0 0 1", wdq.out_vld, wdq.wdq_rptr, wdq.wdq_rd_en, wdq.wdq_empty);
            end
        end
        @(negedge clk);
        push_entry(4'b0000);
        push_entry(4'b0010);
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            if (wdq.out_vld && wdq.out_rdy) begin
                n_pop++;
                n_chk++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL rst_resume_pop: unexpected entry %h", wdq.out_data); end
                else begin
                    exp = sb.pop_front();
                    if ({wdq.out_ecc_err, wdq.out_data} !== exp) begin
                        n_fail++;
                        $display("FAIL rst_resume_pop: got err=%b data=%h want err=%b data=%h", wdq.out_ecc_err, wdq.out_data, exp[131:128], exp[127:0]);
                    end
                end
            end
        end
        n_chk++;
        if (n_pop != 2 || wdq.wdq_rptr !== 5'd2) begin n_fail++; $display("FAIL rst_resume_drain: got %0d pops rptr=%0d want 2 2", n_pop, wdq.wdq_rptr); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_ecc();
        test_reset_midop();
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
